// File: rtl/audio_pkg.sv
// Shared audio definitions: envelope state codes and offset-binary / envelope scale helpers.
package audio_pkg;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ATTACK  = 3'd1;
  localparam logic [2:0] DECAY   = 3'd2;
  localparam logic [2:0] SUSTAIN = 3'd3;
  localparam logic [2:0] RELEASE = 3'd4;

  typedef enum logic [2:0] {
    StIdle    = IDLE,
    StAttack  = ATTACK,
    StDecay   = DECAY,
    StSustain = SUSTAIN,
    StRelease = RELEASE
  } env_state_e;

  // Offset-binary midscale: the DAC code that means silence.
  function automatic int unsigned mid_of(input int unsigned bitdepth);
    return 32'd1 << (bitdepth - 32'd1);
  endfunction

  function automatic int unsigned full_of(input int unsigned envdepth);
    return (32'd1 << envdepth) - 32'd1;
  endfunction

endpackage

// File: rtl/adsr_envelope_if.sv
// Control and sample bundle between the envelope and its surroundings.
interface adsr_envelope_if #(
  parameter int unsigned BITDEPTH = 12,
  parameter int unsigned ENVDEPTH = 16
) ();

  logic                gate;
  logic [ENVDEPTH-1:0] attack_inc;
  logic [ENVDEPTH-1:0] decay_dec;
  logic [ENVDEPTH-1:0] sustain_level;
  logic [ENVDEPTH-1:0] release_dec;
  logic [BITDEPTH-1:0] pcm_in;
  logic [BITDEPTH-1:0] pcm_out;
  logic [ENVDEPTH-1:0] env_level;
  logic [2:0]          env_state;

  modport master (
    output gate, attack_inc, decay_dec, sustain_level, release_dec, pcm_in,
    input  pcm_out, env_level, env_state
  );

  modport slave (
    input  gate, attack_inc, decay_dec, sustain_level, release_dec, pcm_in,
    output pcm_out, env_level, env_state
  );

endinterface

// File: rtl/env_scaler.sv
// Two-stage multiply-and-recentre: scales an offset-binary sample about midscale by the envelope.
module env_scaler
  import audio_pkg::*;
#(
  parameter int unsigned BITDEPTH = 12,
  parameter int unsigned ENVDEPTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                t1_en,
  input  logic                t2_en,
  input  logic [BITDEPTH-1:0] pcm,
  input  logic [ENVDEPTH-1:0] level,
  output logic [BITDEPTH-1:0] pcm_out
);

  localparam int unsigned ProdW = BITDEPTH + ENVDEPTH + 1;
  localparam logic [BITDEPTH-1:0] Mid = BITDEPTH'(mid_of(BITDEPTH));
  localparam logic signed [ProdW-1:0] MidW = ProdW'(mid_of(BITDEPTH));
  localparam logic signed [ProdW-1:0] MaxW = ProdW'(2 * mid_of(BITDEPTH) - 1);

  logic signed [BITDEPTH-1:0] centred;
  logic signed [ProdW-1:0]    prod_d, prod_q, recentred;
  logic [BITDEPTH-1:0]        out_d, pcm_out_q;

  // Flipping the MSB of offset-binary is the same as subtracting midscale.
  assign centred = $signed({~pcm[BITDEPTH-1], pcm[BITDEPTH-2:0]});

  always_comb begin
    prod_d    = ProdW'(centred) * $signed(ProdW'({1'b0, level}));
    recentred = (prod_q >>> ENVDEPTH) + MidW;
    if (recentred[ProdW-1]) begin
      out_d = '0;
    end else if (recentred > MaxW) begin
      out_d = '1;
    end else begin
      out_d = recentred[BITDEPTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q    <= '0;
      pcm_out_q <= Mid;
    end else begin
      if (t1_en) prod_q <= prod_d;
      if (t2_en) pcm_out_q <= out_d;
    end
  end

  assign pcm_out = pcm_out_q;

endmodule

// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope: gate-driven level FSM advanced on sample ticks, feeding the scaler.
module adsr_envelope
  import audio_pkg::*;
#(
  parameter int unsigned BITDEPTH = 12,
  parameter int unsigned ENVDEPTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sample_clock,
  adsr_envelope_if.slave bus
);

  localparam logic [ENVDEPTH-1:0] Full = ENVDEPTH'(full_of(ENVDEPTH));

  logic                sc_q, gate_q, t1_en_q, t2_en_q;
  logic                tick, rise, fall;
  env_state_e          state_q;
  logic [ENVDEPTH-1:0] level_q;
  logic [BITDEPTH-1:0] pcm_q;
  logic [ENVDEPTH:0]   attack_sum, decay_floor;

  assign tick = sample_clock & ~sc_q;
  assign rise = bus.gate & ~gate_q;
  assign fall = ~bus.gate & gate_q;

  // One extra bit so neither sum can wrap.
  assign attack_sum  = {1'b0, level_q} + {1'b0, bus.attack_inc};
  assign decay_floor = {1'b0, bus.sustain_level} + {1'b0, bus.decay_dec};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc_q    <= 1'b0;
      gate_q  <= 1'b0;
      t1_en_q <= 1'b0;
      t2_en_q <= 1'b0;
      pcm_q   <= '0;
    end else begin
      sc_q    <= sample_clock;
      t1_en_q <= tick;
      t2_en_q <= t1_en_q;
      if (tick) begin
        gate_q <= bus.gate;
        pcm_q  <= bus.pcm_in;
      end
    end
  end

  // Gate-edge entries into ATTACK/RELEASE leave the level untouched on that tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      level_q <= '0;
    end else if (tick) begin
      case (state_q)
        StIdle: begin
          level_q <= '0;
          if (rise) state_q <= StAttack;
        end
        StAttack: begin
          if (fall) begin
            state_q <= StRelease;
          end else if (attack_sum >= {1'b0, Full}) begin
            level_q <= Full;
            state_q <= StDecay;
          end else begin
            level_q <= attack_sum[ENVDEPTH-1:0];
          end
        end
        StDecay: begin
          if (fall) begin
            state_q <= StRelease;
          end else if ({1'b0, level_q} <= decay_floor) begin
            level_q <= bus.sustain_level;
            state_q <= StSustain;
          end else begin
            level_q <= level_q - bus.decay_dec;
          end
        end
        StSustain: begin
          if (fall) state_q <= StRelease;
          else      level_q <= bus.sustain_level;
        end
        StRelease: begin
          if (rise) begin
            state_q <= StAttack;
          end else if (level_q <= bus.release_dec) begin
            level_q <= '0;
            state_q <= StIdle;
          end else begin
            level_q <= level_q - bus.release_dec;
          end
        end
        default: begin
          state_q <= StIdle;
          level_q <= '0;
        end
      endcase
    end
  end

  assign bus.env_level = level_q;
  assign bus.env_state = state_q;

  env_scaler #(
    .BITDEPTH(BITDEPTH),
    .ENVDEPTH(ENVDEPTH)
  ) u_scaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .t1_en  (t1_en_q),
    .t2_en  (t2_en_q),
    .pcm    (pcm_q),
    .level  (level_q),
    .pcm_out(bus.pcm_out)
  );

endmodule

// File: tb/tb_adsr_envelope.sv
// Self-checking bench for adsr_envelope: directed ticks, per-cycle model compare, literal anchors.
module tb_adsr_envelope;

  localparam int BD = 12;
  localparam int ED = 16;
  localparam int Mid = 2048;
  localparam int FullV = 65535;
  localparam int PMax = 4095;
  localparam int SIdle = 0, SAttack = 1, SDecay = 2, SSustain = 3, SRelease = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sample_clock = 1'b0;

  adsr_envelope_if #(.BITDEPTH(BD), .ENVDEPTH(ED)) bus ();

  adsr_envelope #(.BITDEPTH(BD), .ENVDEPTH(ED)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_clock(sample_clock),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit cmp_en = 1'b0;

  int m_level, m_state, m_exp_pcm, m_pend_pcm;
  bit m_gate;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Midscale plus floor((pcm - mid) * level / 2^ED), clamped to the DAC range.
  function automatic int scaled(input int pcm, input int lvl);
    int p, q, r;
    p = (pcm - Mid) * lvl;
    q = p / 65536;
    if (p < 0 && q * 65536 != p) q = q - 1;
    r = Mid + q;
    if (r < 0) r = 0;
    if (r > PMax) r = PMax;
    return r;
  endfunction

  task automatic model_reset();
    m_level = 0;
    m_state = SIdle;
    m_gate = 1'b0;
    m_exp_pcm = Mid;
    m_pend_pcm = Mid;
  endtask

  task automatic model_step(input bit g, input int pcm);
    bit rise, fall;
    int att, dec, sus, rel;
    rise = g && !m_gate;
    fall = !g && m_gate;
    att = int'(bus.attack_inc);
    dec = int'(bus.decay_dec);
    sus = int'(bus.sustain_level);
    rel = int'(bus.release_dec);
    case (m_state)
      SIdle:    if (rise) m_state = SAttack; else m_level = 0;
      SAttack:
        if (fall) m_state = SRelease;
        else if (m_level + att >= FullV) begin m_level = FullV; m_state = SDecay; end
        else m_level = m_level + att;
      SDecay:
        if (fall) m_state = SRelease;
        else if (m_level <= sus + dec) begin m_level = sus; m_state = SSustain; end
        else m_level = m_level - dec;
      SSustain: if (fall) m_state = SRelease; else m_level = sus;
      default:
        if (rise) m_state = SAttack;
        else if (m_level <= rel) begin m_level = 0; m_state = SIdle; end
        else m_level = m_level - rel;
    endcase
    m_gate = g;
    m_pend_pcm = scaled(pcm, m_level);
  endtask

  // One sample period: 4 clk high, 4 clk low; the model follows the DUT's tick timing.
  task automatic tick(input bit g, input int pcm);
    @(negedge clk);
    bus.gate = g;
    bus.pcm_in = 12'(pcm);
    sample_clock = 1'b1;
    @(posedge clk);
    #1 model_step(g, pcm);
    @(posedge clk);
    @(posedge clk);
    #1 m_exp_pcm = m_pend_pcm;
    repeat (2) @(negedge clk);
    sample_clock = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      check("env_level", bus.env_level, m_level);
      check("env_state", bus.env_state, m_state);
      check("pcm_out", bus.pcm_out, m_exp_pcm);
    end
  end

  initial begin
    bus.gate = 1'b0;
    bus.pcm_in = 12'd4095;
    bus.attack_inc = 16'h4000;
    bus.decay_dec = 16'h1000;
    bus.sustain_level = 16'h8000;
    bus.release_dec = 16'h2000;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("reset pcm_out", bus.pcm_out, 2048);
    check("reset env_level", bus.env_level, 0);
    check("reset env_state", bus.env_state, SIdle);
    cmp_en = 1'b1;

    // Full ADSR cycle
    tick(1'b1, 4095);
    check("attack entry state", bus.env_state, SAttack);
    check("attack entry level", bus.env_level, 0);
    for (int i = 0; i < 4; i++) tick(1'b1, 4095);
    check("full level", bus.env_level, 16'hFFFF);
    check("decay state", bus.env_state, SDecay);
    check("full scale pcm", bus.pcm_out, 4094);
    for (int i = 0; i < 8; i++) tick(1'b1, 4095);
    check("sustain level", bus.env_level, 16'h8000);
    check("sustain state", bus.env_state, SSustain);
    check("half scale pcm", bus.pcm_out, 3071);
    tick(1'b0, 4095);
    check("release entry state", bus.env_state, SRelease);
    check("release entry level", bus.env_level, 16'h8000);
    for (int i = 0; i < 3; i++) tick(1'b0, 4095);
    check("release level", bus.env_level, 16'h2000);
    tick(1'b0, 4095);
    check("release end state", bus.env_state, SIdle);
    check("release end level", bus.env_level, 0);
    check("silence pcm", bus.pcm_out, 2048);
    tick(1'b0, 0);
    check("level0 pcm low input", bus.pcm_out, 2048);

    // Retrigger from release, and fall on the saturating tick
    bus.release_dec = 16'h1000;
    tick(1'b1, 4095);
    tick(1'b1, 4095);
    tick(1'b0, 4095);
    tick(1'b0, 4095);
    check("release at 3000", bus.env_level, 16'h3000);
    tick(1'b1, 4095);
    check("retrigger state", bus.env_state, SAttack);
    check("retrigger level held", bus.env_level, 16'h3000);
    tick(1'b1, 4095);
    check("attack from 3000", bus.env_level, 16'h7000);
    tick(1'b1, 4095);
    tick(1'b1, 4095);
    check("attack F000", bus.env_level, 16'hF000);
    tick(1'b0, 4095);
    check("fall at saturation state", bus.env_state, SRelease);
    check("fall at saturation level", bus.env_level, 16'hF000);
    bus.release_dec = 16'hFFFF;
    tick(1'b0, 4095);
    check("big release idle", bus.env_state, SIdle);

    // Boundaries: zero attack rate, live sustain change, sub-tick gate pulse
    bus.attack_inc = 16'h0000;
    for (int i = 0; i < 4; i++) tick(1'b1, 1000);
    check("zero attack state", bus.env_state, SAttack);
    check("zero attack level", bus.env_level, 0);
    bus.attack_inc = 16'h8000;
    for (int i = 0; i < 10; i++) tick(1'b1, 0);
    check("sustain again state", bus.env_state, SSustain);
    check("low pcm half scale", bus.pcm_out, 1024);
    bus.sustain_level = 16'h2000;
    tick(1'b1, 0);
    check("sustain tracks", bus.env_level, 16'h2000);
    check("sustain tracks pcm", bus.pcm_out, 1792);
    bus.release_dec = 16'h0800;
    for (int i = 0; i < 5; i++) tick(1'b0, 0);
    check("release 0800 idle", bus.env_state, SIdle);
    @(negedge clk);
    bus.gate = 1'b1;
    repeat (3) @(negedge clk);
    bus.gate = 1'b0;
    tick(1'b0, 0);
    tick(1'b0, 0);
    check("pulse ignored", bus.env_state, SIdle);

    // Asynchronous reset mid-attack
    bus.attack_inc = 16'h1000;
    tick(1'b1, 4095);
    tick(1'b1, 4095);
    tick(1'b1, 4095);
    check("pre-reset pcm", bus.pcm_out, 2303);
    @(posedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("async reset pcm", bus.pcm_out, 2048);
    check("async reset level", bus.env_level, 0);
    check("async reset state", bus.env_state, SIdle);
    bus.gate = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b0, 4095);
    tick(1'b0, 4095);
    check("post-reset state", bus.env_state, SIdle);
    check("post-reset pcm", bus.pcm_out, 2048);

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
